branch_resolve_unit: RTL and testbench

//  Execute-stage branch/jump resolver. Drives the fetch redirect pair (j, jPC).

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_cmp.sv | 30 +++
 rtl/branch_resolve_unit.sv | 143 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the execute-stage branch resolver: operation encoding,
// branch condition codes and resolver FSM states.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_BRANCH = 2'd1,
        BR_JAL    = 2'd2,
        BR_JALR   = 2'd3
    } br_op_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bru_state_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational RV32I branch condition evaluator; codes 010/011 are not
// branches and report illegal instead of taken.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic [bits-1:0] rs1_i,
    input  logic [bits-1:0] rs2_i,
    input  logic [2:0]      funct3_i,
    output logic            taken_o,
    output logic            illegal_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rs1_i == rs2_i);
            F3_BNE:  taken_o = (rs1_i != rs2_i);
            F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: taken_o = (rs1_i <  rs2_i);
            F3_BGEU: taken_o = (rs1_i >= rs2_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: registered fetch redirect (j, jPC),
// wrong-path squash for FLUSH_DEPTH cycles, and JAL/JALR link writeback.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int bits        = 32,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [1:0]      op_i,
    input  logic [2:0]      funct3_i,
    input  logic [bits-1:0] PC_i,
    input  logic [bits-1:0] NPC_i,
    input  logic [bits-1:0] rs1_i,
    input  logic [bits-1:0] rs2_i,
    input  logic [bits-1:0] imm_i,
    output logic            j,
    output logic [bits-1:0] jPC,
    output logic            flush,
    output logic            link_we,
    output logic [bits-1:0] link_o,
    output logic            misalign,
    output logic            illegal
);

    localparam int            CW       = $clog2(FLUSH_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_DEPTH - 1);

    br_op_t          w_op;
    logic            w_cond_taken;
    logic            w_cond_illegal;
    logic [bits-1:0] w_sum;
    logic [bits-1:0] w_target;
    logic            w_is_jump;
    logic            w_is_branch;
    logic            w_accept;
    logic            w_taken;
    logic            w_redirect;
    logic            w_misalign;
    logic            w_illegal;
    logic            w_link;

    bru_state_t      r_state;
    bru_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    logic            r_j;
    logic [bits-1:0] r_jpc;
    logic            r_link_we;
    logic [bits-1:0] r_link;
    logic            r_misalign;
    logic            r_illegal;

    assign w_op = br_op_t'(op_i);

    branch_cmp #(.bits(bits)) u_cmp (
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .funct3_i  (funct3_i),
        .taken_o   (w_cond_taken),
        .illegal_o (w_cond_illegal)
    );

    // JALR clears bit 0 of the sum; bit 1 is what decides misalignment.
    assign w_sum    = ((w_op == BR_JALR) ? rs1_i : PC_i) + imm_i;
    assign w_target = (w_op == BR_JALR) ? {w_sum[bits-1:1], 1'b0} : w_sum;

    assign w_is_jump   = (w_op == BR_JAL) || (w_op == BR_JALR);
    assign w_is_branch = (w_op == BR_BRANCH);
    assign w_accept    = (r_state == IDLE) && valid_i && (w_op != BR_NONE);
    assign w_taken     = w_is_jump || (w_is_branch && w_cond_taken);
    assign w_redirect  = w_accept && w_taken && !w_target[1];
    assign w_misalign  = w_accept && w_taken &&  w_target[1];
    assign w_illegal   = w_accept && w_is_branch && w_cond_illegal;
    assign w_link      = w_redirect && w_is_jump;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_redirect) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_j        <= 1'b0;
            r_jpc      <= '0;
            r_link_we  <= 1'b0;
            r_link     <= '0;
            r_misalign <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_j        <= w_redirect;
            r_link_we  <= w_link;
            r_misalign <= w_misalign;
            r_illegal  <= w_illegal;
            if (w_redirect) begin
                r_jpc <= w_target;
            end
            if (w_link) begin
                r_link <= NPC_i;
            end
        end
    end

    // flush is a pure decode of the state flop, so it is high exactly while in FLUSH.
    assign flush    = (r_state == FLUSH);
    assign j        = r_j;
    assign jPC      = r_jpc;
    assign link_we  = r_link_we;
    assign link_o   = r_link;
    assign misalign = r_misalign;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver queues the expected
// registered response for each cycle, the monitor pops and compares it.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [1:0]  op_i;
    logic [2:0]  funct3_i;
    logic [31:0] PC_i;
    logic [31:0] NPC_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [31:0] imm_i;
    logic        j;
    logic [31:0] jPC;
    logic        flush;
    logic        link_we;
    logic [31:0] link_o;
    logic        misalign;
    logic        illegal;

    typedef struct {
        logic        j;
        logic [31:0] jpc;
        logic        flush;
        logic        lwe;
        logic [31:0] link;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          n_checks;
    int          n_errors;
    logic [31:0] t_jpc;
    logic [31:0] t_link;

    branch_resolve_unit #(.bits(32), .FLUSH_DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .funct3_i (funct3_i),
        .PC_i     (PC_i),
        .NPC_i    (NPC_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .imm_i    (imm_i),
        .j        (j),
        .jPC      (jPC),
        .flush    (flush),
        .link_we  (link_we),
        .link_o   (link_o),
        .misalign (misalign),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Monitor: one registered response per driven cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("j",        {31'd0, j},        {31'd0, e.j});
                check("jPC",      jPC,               e.jpc);
                check("flush",    {31'd0, flush},    {31'd0, e.flush});
                check("link_we",  {31'd0, link_we},  {31'd0, e.lwe});
                check("link_o",   link_o,            e.link);
                check("misalign", {31'd0, misalign}, {31'd0, e.mis});
                check("illegal",  {31'd0, illegal},  {31'd0, e.ill});
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm,
                        input logic ej, input logic ef, input logic el, input logic em, input logic ei);
        exp_t e;
        e.j = ej; e.jpc = t_jpc; e.flush = ef; e.lwe = el; e.link = t_link; e.mis = em; e.ill = ei;
        q.push_back(e);
        rst = r; valid_i = v; op_i = op; funct3_i = f3;
        PC_i = pc; NPC_i = npc; rs1_i = a; rs2_i = b; imm_i = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ef);
        step(1'b0, 1'b0, BR_NONE, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, ef, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        t_jpc    = 32'd0;
        t_link   = 32'd0;

        // Reset with a valid JAL present: rst must win.
        step(1'b1, 1'b1, BR_JAL, 3'd0, 32'h100, 32'h104, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        // 1. BEQ taken: redirect then two flush cycles.
        t_jpc = 32'h120;
        step(1'b0, 1'b1, BR_BRANCH, F3_BEQ, 32'h100, 32'h104, 32'd5, 32'd5, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // 2. BNE not taken, then back-to-back BGEU 3>=1 taken.
        step(1'b0, 1'b1, BR_BRANCH, F3_BNE, 32'h180, 32'h184, 32'd7, 32'd7, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        t_jpc = 32'h240;
        step(1'b0, 1'b1, BR_BRANCH, F3_BGEU, 32'h200, 32'h204, 32'd3, 32'd1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // 3. JALR: (0x1001+4)&~1 = 0x1004, link = NPC.
        t_jpc  = 32'h1004;
        t_link = 32'h208;
        step(1'b0, 1'b1, BR_JALR, 3'd0, 32'h204, 32'h208, 32'h1001, 32'd0, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // 4. BLT -1 < 1 taken (target 0x300-0x10), BLTU same operands not taken.
        t_jpc = 32'h2F0;
        step(1'b0, 1'b1, BR_BRANCH, F3_BLT, 32'h300, 32'h304, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        step(1'b0, 1'b1, BR_BRANCH, F3_BLTU, 32'h300, 32'h304, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5. JAL to 0x102 misaligned; illegal funct3; JAL target wrapping past 2^32.
        step(1'b0, 1'b1, BR_JAL, 3'd0, 32'h100, 32'h104, 32'd0, 32'd0, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, BR_BRANCH, 3'b010, 32'h100, 32'h104, 32'd1, 32'd1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, BR_BRANCH, 3'b011, 32'h100, 32'h104, 32'd1, 32'd2, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        t_jpc  = 32'h10;
        t_link = 32'hFFFF_FFF4;
        step(1'b0, 1'b1, BR_JAL, 3'd0, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'd0, 32'd0, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // 6a. Valid JAL held into FLUSH must not redirect again.
        t_jpc  = 32'h500;
        t_link = 32'h404;
        step(1'b0, 1'b1, BR_JAL, 3'd0, 32'h400, 32'h404, 32'd0, 32'd0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, BR_JAL, 3'd0, 32'h400, 32'h404, 32'd0, 32'd0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        // 6b. rst in the first FLUSH cycle clears everything and discards the count.
        t_jpc  = 32'h608;
        t_link = 32'h604;
        step(1'b0, 1'b1, BR_JAL, 3'd0, 32'h600, 32'h604, 32'd0, 32'd0, 32'h8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        t_jpc  = 32'd0;
        t_link = 32'd0;
        step(1'b1, 1'b1, BR_JAL, 3'd0, 32'h600, 32'h604, 32'd0, 32'd0, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        t_jpc = 32'h18;
        step(1'b0, 1'b1, BR_BRANCH, F3_BEQ, 32'h10, 32'h14, 32'd0, 32'd0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
